// File: rtl/nand_apb_regs.sv
// APB3 register front-end for the NAND flash FSM: control registers, start/done
// handshake, status capture and TX/RX byte FIFOs. Optional IRQ via NAND_APB_IRQ_EN.
module nand_apb_regs #(
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_AW    = 3
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [7:0]  PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic [15:0] C_Cmd,
    output logic [39:0] C_Addr,
    output logic [7:0]  C_Length,
    output logic        C_Start,
    input  logic        C_Done,
    input  logic [7:0]  C_Status,
    input  logic        F_nRB,
    output logic [7:0]  D_TxData,
    output logic        D_TxEmpty,
    input  logic        D_TxPop,
    input  logic [7:0]  D_RxData,
    input  logic        D_RxPush,
    output logic        D_RxFull
`ifdef NAND_APB_IRQ_EN
    ,
    output logic        IRQ
`endif
);

    localparam logic [7:0] A_CMD    = 8'h00;
    localparam logic [7:0] A_ADDR0  = 8'h04;
    localparam logic [7:0] A_ADDR1  = 8'h08;
    localparam logic [7:0] A_LEN    = 8'h0C;
    localparam logic [7:0] A_CTRL   = 8'h10;
    localparam logic [7:0] A_STATUS = 8'h14;
    localparam logic [7:0] A_DATA   = 8'h18;
    localparam logic [7:0] A_IE     = 8'h1C;
    localparam logic [FIFO_AW:0] PTR_ONE = 1;

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t      state;
    logic [15:0] cmd_q;
    logic [39:0] addr_q;
    logic [7:0]  len_q;
    logic [7:0]  status_q;
    logic        start_q, done_q, tx_ovf_q, rx_unf_q, rx_ovf_q;
    logic        busy;

    logic [7:0]       tx_mem [FIFO_DEPTH];
    logic [7:0]       rx_mem [FIFO_DEPTH];
    logic [FIFO_AW:0] tx_wp, tx_rp, rx_wp, rx_rp;
    logic             tx_empty, tx_full, rx_empty, rx_full;
    logic [7:0]       rx_head;

    logic xfer, wr, rd, mapped, err, ok_wr, ok_rd;
    logic sel_cmd, sel_addr0, sel_addr1, sel_len, sel_ctrl, sel_status, sel_data, sel_ie;
    logic tx_push, tx_pop, tx_flush, rx_push, rx_pop, rx_flush, start_ok;

`ifdef NAND_APB_IRQ_EN
    logic [1:0] ie_q;
    logic       irq_q;
    assign IRQ = irq_q;
`endif

    assign busy = (state == S_RUN);

    assign sel_cmd    = (PADDR == A_CMD);
    assign sel_addr0  = (PADDR == A_ADDR0);
    assign sel_addr1  = (PADDR == A_ADDR1);
    assign sel_len    = (PADDR == A_LEN);
    assign sel_ctrl   = (PADDR == A_CTRL);
    assign sel_status = (PADDR == A_STATUS);
    assign sel_data   = (PADDR == A_DATA);
`ifdef NAND_APB_IRQ_EN
    assign sel_ie     = (PADDR == A_IE);
`else
    assign sel_ie     = 1'b0;
`endif
    assign mapped = sel_cmd | sel_addr0 | sel_addr1 | sel_len | sel_ctrl |
                    sel_status | sel_data | sel_ie;

    assign xfer = PSEL & PENABLE;
    assign wr   = xfer & PWRITE;
    assign rd   = xfer & ~PWRITE;

    // Any error condition suppresses every side effect except the sticky error flags.
    always_comb begin
        err = 1'b0;
        if (!mapped)
            err = 1'b1;
        else if (PWRITE && (sel_cmd || sel_addr0 || sel_addr1 || sel_len) && busy)
            err = 1'b1;
        else if (PWRITE && sel_ctrl && PWDATA[0] && busy)
            err = 1'b1;
        else if (PWRITE && sel_data && tx_full)
            err = 1'b1;
        else if (!PWRITE && sel_data && rx_empty)
            err = 1'b1;
    end

    assign ok_wr   = wr & ~err;
    assign ok_rd   = rd & ~err;
    assign PSLVERR = xfer & err;
    assign PREADY  = 1'b1;

    assign start_ok = ok_wr & sel_ctrl & PWDATA[0];
    assign tx_push  = ok_wr & sel_data;
    assign tx_flush = ok_wr & sel_ctrl & PWDATA[1];
    assign tx_pop   = D_TxPop & ~tx_empty;
    assign rx_push  = D_RxPush & ~rx_full;
    assign rx_flush = ok_wr & sel_ctrl & PWDATA[2];
    assign rx_pop   = ok_rd & sel_data;

    assign tx_empty = (tx_wp == tx_rp);
    assign tx_full  = (tx_wp[FIFO_AW] != tx_rp[FIFO_AW]) &&
                      (tx_wp[FIFO_AW-1:0] == tx_rp[FIFO_AW-1:0]);
    assign rx_empty = (rx_wp == rx_rp);
    assign rx_full  = (rx_wp[FIFO_AW] != rx_rp[FIFO_AW]) &&
                      (rx_wp[FIFO_AW-1:0] == rx_rp[FIFO_AW-1:0]);

    assign D_TxData  = tx_mem[tx_rp[FIFO_AW-1:0]];
    assign D_TxEmpty = tx_empty;
    assign D_RxFull  = rx_full;
    assign rx_head   = rx_mem[rx_rp[FIFO_AW-1:0]];

    assign C_Cmd    = cmd_q;
    assign C_Addr   = addr_q;
    assign C_Length = len_q;
    assign C_Start  = start_q;

    always_comb begin
        PRDATA = 32'h0;
        if (PSEL) begin
            case (PADDR)
                A_CMD:    PRDATA = {16'h0, cmd_q};
                A_ADDR0:  PRDATA = addr_q[31:0];
                A_ADDR1:  PRDATA = {24'h0, addr_q[39:32]};
                A_LEN:    PRDATA = {24'h0, len_q};
                A_STATUS: PRDATA = {16'h0, rx_ovf_q, rx_unf_q, tx_ovf_q, rx_empty,
                                    tx_full, F_nRB, done_q, busy, status_q};
                A_DATA:   PRDATA = rx_empty ? 32'h0 : {24'h0, rx_head};
`ifdef NAND_APB_IRQ_EN
                A_IE:     PRDATA = {30'h0, ie_q};
`endif
                default:  PRDATA = 32'h0;
            endcase
        end
    end

    // Memories carry no reset; pointers alone define what is valid.
    always_ff @(posedge PCLK) begin
        if (tx_push) tx_mem[tx_wp[FIFO_AW-1:0]] <= PWDATA[7:0];
        if (rx_push) rx_mem[rx_wp[FIFO_AW-1:0]] <= D_RxData;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            tx_wp <= '0;
            tx_rp <= '0;
            rx_wp <= '0;
            rx_rp <= '0;
        end else begin
            if (tx_flush) begin
                tx_wp <= '0;
                tx_rp <= '0;
            end else begin
                if (tx_push) tx_wp <= tx_wp + PTR_ONE;
                if (tx_pop)  tx_rp <= tx_rp + PTR_ONE;
            end
            if (rx_flush) begin
                rx_wp <= '0;
                rx_rp <= '0;
            end else begin
                if (rx_push) rx_wp <= rx_wp + PTR_ONE;
                if (rx_pop)  rx_rp <= rx_rp + PTR_ONE;
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state    <= S_IDLE;
            cmd_q    <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            status_q <= '0;
            start_q  <= 1'b0;
            done_q   <= 1'b0;
            tx_ovf_q <= 1'b0;
            rx_unf_q <= 1'b0;
            rx_ovf_q <= 1'b0;
        end else begin
            start_q <= 1'b0;
            if (ok_wr && sel_cmd)   cmd_q          <= PWDATA[15:0];
            if (ok_wr && sel_addr0) addr_q[31:0]   <= PWDATA;
            if (ok_wr && sel_addr1) addr_q[39:32]  <= PWDATA[7:0];
            if (ok_wr && sel_len)   len_q          <= PWDATA[7:0];

            // W1C clears come first so a same-cycle set wins.
            if (ok_wr && sel_status) begin
                if (PWDATA[9])  done_q   <= 1'b0;
                if (PWDATA[13]) tx_ovf_q <= 1'b0;
                if (PWDATA[14]) rx_unf_q <= 1'b0;
                if (PWDATA[15]) rx_ovf_q <= 1'b0;
            end
            if (wr && sel_data && tx_full)              tx_ovf_q <= 1'b1;
            if (rd && sel_data && rx_empty)             rx_unf_q <= 1'b1;
            if (D_RxPush && rx_full && !rx_flush)       rx_ovf_q <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        start_q <= 1'b1;
                        done_q  <= 1'b0;
                        state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (C_Done) begin
                        status_q <= C_Status;
                        done_q   <= 1'b1;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef NAND_APB_IRQ_EN
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            ie_q  <= 2'b00;
            irq_q <= 1'b0;
        end else begin
            if (ok_wr && sel_ie) ie_q <= PWDATA[1:0];
            irq_q <= (done_q & ie_q[0]) | ((tx_ovf_q | rx_ovf_q | rx_unf_q) & ie_q[1]);
        end
    end
`endif

endmodule

// File: tb/tb_nand_apb_regs.sv
// Directed bench for nand_apb_regs: register map, start/done handshake, error
// responses, TX/RX FIFO ordering and wrap, and mid-run reset.
module tb_nand_apb_regs;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        PSEL, PENABLE, PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic [15:0] C_Cmd;
    logic [39:0] C_Addr;
    logic [7:0]  C_Length;
    logic        C_Start;
    logic        C_Done;
    logic [7:0]  C_Status;
    logic        F_nRB;
    logic [7:0]  D_TxData;
    logic        D_TxEmpty;
    logic        D_TxPop;
    logic [7:0]  D_RxData;
    logic        D_RxPush;
    logic        D_RxFull;
`ifdef NAND_APB_IRQ_EN
    logic        IRQ;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int start_cnt = 0;
    logic [7:0] exp_q[$];

    nand_apb_regs #(.FIFO_DEPTH(8), .FIFO_AW(3)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .C_Cmd(C_Cmd), .C_Addr(C_Addr),
        .C_Length(C_Length), .C_Start(C_Start), .C_Done(C_Done),
        .C_Status(C_Status), .F_nRB(F_nRB), .D_TxData(D_TxData),
        .D_TxEmpty(D_TxEmpty), .D_TxPop(D_TxPop), .D_RxData(D_RxData),
        .D_RxPush(D_RxPush), .D_RxFull(D_RxFull)
`ifdef NAND_APB_IRQ_EN
        , .IRQ(IRQ)
`endif
    );

    // clock and watchdog
    always #5 PCLK = ~PCLK;

    always @(posedge PCLK) if (C_Start === 1'b1) start_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic apb_write(input logic [7:0] a, input logic [31:0] d,
                             input logic with_done, output logic e);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        @(negedge PCLK);
        PENABLE = 1'b1;
        if (with_done) C_Done = 1'b1;
        #1 e = PSLVERR;
        @(posedge PCLK);
        #1 PSEL = 1'b0; PENABLE = 1'b0; C_Done = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output logic e);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1 d = PRDATA; e = PSLVERR;
        @(posedge PCLK);
        #1 PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic done_pulse(input logic [7:0] st);
        @(negedge PCLK);
        C_Done = 1'b1; C_Status = st;
        @(posedge PCLK);
        #1 C_Done = 1'b0;
    endtask

    task automatic tx_pop_check(input string tag);
        logic [7:0] e;
        @(negedge PCLK);
        e = exp_q.pop_front();
        check(tag, {56'h0, D_TxData}, {56'h0, e});
        D_TxPop = 1'b1;
        @(posedge PCLK);
        #1 D_TxPop = 1'b0;
    endtask

    task automatic rx_push(input logic [7:0] b);
        @(negedge PCLK);
        D_RxPush = 1'b1; D_RxData = b;
        @(posedge PCLK);
        #1 D_RxPush = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge PCLK);
        PRESET = 1'b1;
        @(posedge PCLK);
        @(posedge PCLK);
        #1 PRESET = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        e;
        int          s0;
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = 8'h0; PWDATA = 32'h0; C_Done = 1'b0; C_Status = 8'h0;
        F_nRB = 1'b1; D_TxPop = 1'b0; D_RxData = 8'h0; D_RxPush = 1'b0;
        do_reset();

        // reset state
        apb_read(8'h14, rd, e);
        check("rst_status", {32'h0, rd}, 64'h1400);
        check("rst_err", {63'h0, e}, 64'h0);
        check("rst_start", {63'h0, C_Start}, 64'h0);
        check("rst_txempty", {63'h0, D_TxEmpty}, 64'h1);
        check("rst_rxfull", {63'h0, D_RxFull}, 64'h0);

        // control registers and start pulse
        apb_write(8'h00, 32'h0000_3000, 1'b0, e);
        apb_write(8'h04, 32'h1234_5678, 1'b0, e);
        apb_write(8'h08, 32'h0000_00AB, 1'b0, e);
        apb_write(8'h0C, 32'h0000_0010, 1'b0, e);
        check("cmd_out", {48'h0, C_Cmd}, 64'h3000);
        check("addr_out", {24'h0, C_Addr}, 64'hAB_1234_5678);
        check("len_out", {56'h0, C_Length}, 64'h10);
        apb_read(8'h08, rd, e);
        check("addr1_rd", {32'h0, rd}, 64'hAB);
        s0 = start_cnt;
        apb_write(8'h10, 32'h1, 1'b0, e);
        check("start_err", {63'h0, e}, 64'h0);
        check("start_hi", {63'h0, C_Start}, 64'h1);
        @(posedge PCLK); #1;
        check("start_lo", {63'h0, C_Start}, 64'h0);
        check("start_cnt", start_cnt - s0, 64'd1);
        apb_read(8'h14, rd, e);
        check("busy_status", {32'h0, rd}, 64'h1500);

        // writes while busy are rejected
        apb_write(8'h00, 32'h0000_1111, 1'b0, e);
        check("busy_wr_err", {63'h0, e}, 64'h1);
        check("busy_wr_cmd", {48'h0, C_Cmd}, 64'h3000);

        // completion
        done_pulse(8'hC0);
        apb_read(8'h14, rd, e);
        check("done_status", {32'h0, rd}, 64'h16C0);
        apb_write(8'h14, 32'h200, 1'b0, e);
        apb_read(8'h14, rd, e);
        check("done_w1c", {32'h0, rd}, 64'h14C0);

        // START colliding with C_Done while running
        apb_write(8'h10, 32'h1, 1'b0, e);
        repeat (2) @(posedge PCLK);
        #1 s0 = start_cnt;
        C_Status = 8'h5A;
        apb_write(8'h10, 32'h1, 1'b1, e);
        check("coll_err", {63'h0, e}, 64'h1);
        repeat (2) @(posedge PCLK);
        #1 check("coll_nostart", start_cnt - s0, 64'd0);
        apb_read(8'h14, rd, e);
        check("coll_status", {32'h0, rd}, 64'h165A);
        apb_write(8'h14, 32'h200, 1'b0, e);

        // TX FIFO fill, overflow, drain
        for (int i = 1; i <= 8; i++) begin
            apb_write(8'h18, i, 1'b0, e);
            exp_q.push_back(i[7:0]);
        end
        check("tx_notempty", {63'h0, D_TxEmpty}, 64'h0);
        apb_write(8'h18, 32'h09, 1'b0, e);
        check("tx_ovf_err", {63'h0, e}, 64'h1);
        apb_read(8'h14, rd, e);
        check("tx_full_status", {32'h0, rd}, 64'h3C5A);
        for (int i = 0; i < 8; i++) tx_pop_check("tx_data");
        #1 check("tx_empty", {63'h0, D_TxEmpty}, 64'h1);
        apb_write(8'h14, 32'h2000, 1'b0, e);

        // second fill exercises pointer wrap
        for (int i = 0; i < 8; i++) begin
            apb_write(8'h18, 32'h11 + i, 1'b0, e);
            exp_q.push_back(8'h11 + i[7:0]);
        end
        apb_read(8'h14, rd, e);
        check("wrap_full_status", {32'h0, rd}, 64'h1C5A);
        for (int i = 0; i < 4; i++) tx_pop_check("wrap_data");
        apb_write(8'h10, 32'h2, 1'b0, e);
        exp_q.delete();
        #1 check("tx_flush", {63'h0, D_TxEmpty}, 64'h1);
        apb_write(8'h18, 32'h99, 1'b0, e);
        exp_q.push_back(8'h99);
        tx_pop_check("post_flush_data");

        // RX FIFO underflow, overflow, ordered reads
        apb_read(8'h18, rd, e);
        check("rx_unf_data", {32'h0, rd}, 64'h0);
        check("rx_unf_err", {63'h0, e}, 64'h1);
        apb_read(8'h14, rd, e);
        check("rx_unf_status", {32'h0, rd}, 64'h545A);
        for (int i = 0; i < 9; i++) begin
            rx_push(8'h21 + i[7:0]);
            if (i < 8) exp_q.push_back(8'h21 + i[7:0]);
        end
        check("rx_full", {63'h0, D_RxFull}, 64'h1);
        apb_read(8'h14, rd, e);
        check("rx_ovf_status", {32'h0, rd}, 64'hC45A);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] b;
            apb_read(8'h18, rd, e);
            b = exp_q.pop_front();
            check("rx_data", {32'h0, rd}, {56'h0, b});
            check("rx_data_err", {63'h0, e}, 64'h0);
        end
        apb_write(8'h14, 32'hC000, 1'b0, e);
        apb_read(8'h14, rd, e);
        check("rx_drained_status", {32'h0, rd}, 64'h145A);

        // unmapped addresses, write-only CTRL, nRB passthrough
        apb_read(8'h20, rd, e);
        check("unmapped_err", {63'h0, e}, 64'h1);
        check("unmapped_data", {32'h0, rd}, 64'h0);
`ifndef NAND_APB_IRQ_EN
        apb_read(8'h1C, rd, e);
        check("ie_unmapped_err", {63'h0, e}, 64'h1);
`endif
        apb_read(8'h10, rd, e);
        check("ctrl_rd", {32'h0, rd}, 64'h0);
        F_nRB = 1'b0;
        apb_read(8'h14, rd, e);
        check("nrb_low", {32'h0, rd}, 64'h105A);
        F_nRB = 1'b1;

        // reset in the middle of a run
        apb_write(8'h00, 32'h77, 1'b0, e);
        apb_write(8'h04, 32'h55, 1'b0, e);
        apb_write(8'h0C, 32'h04, 1'b0, e);
        apb_write(8'h10, 32'h1, 1'b0, e);
        for (int i = 0; i < 3; i++) apb_write(8'h18, 32'hE0 + i, 1'b0, e);
        check("pre_rst_txempty", {63'h0, D_TxEmpty}, 64'h0);
        do_reset();
        check("mid_rst_cmd", {48'h0, C_Cmd}, 64'h0);
        check("mid_rst_addr", {24'h0, C_Addr}, 64'h0);
        check("mid_rst_len", {56'h0, C_Length}, 64'h0);
        check("mid_rst_txempty", {63'h0, D_TxEmpty}, 64'h1);
        check("mid_rst_start", {63'h0, C_Start}, 64'h0);
        apb_read(8'h14, rd, e);
        check("mid_rst_status", {32'h0, rd}, 64'h1400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
